// File: rtl/free_list_if.sv
// Rename/commit-side handshake bundle for the physical-register free list.
// The master drives requests; the slave (the free list) drives grant, count and error.
interface free_list_if #(
    parameter int unsigned PREG_W = 7,
    parameter int unsigned ROB_W  = 5,
    parameter int unsigned CNT_W  = 7
);
    logic              flush_i;
    logic              recover_i;
    logic [ROB_W-1:0]  recover_tag_i;
    logic              checkpoint_take_i;
    logic [ROB_W-1:0]  checkpoint_tag_i;
    logic              alloc_req_i;
    logic              alloc_valid_o;
    logic [PREG_W-1:0] alloc_preg_o;
    logic              free_req_i;
    logic [PREG_W-1:0] free_preg_i;
    logic [CNT_W-1:0]  count_o;
    logic              err_o;

    modport master (
        output flush_i, recover_i, recover_tag_i, checkpoint_take_i, checkpoint_tag_i,
        output alloc_req_i, free_req_i, free_preg_i,
        input  alloc_valid_o, alloc_preg_o, count_o, err_o
    );

    modport slave (
        input  flush_i, recover_i, recover_tag_i, checkpoint_take_i, checkpoint_tag_i,
        input  alloc_req_i, free_req_i, free_preg_i,
        output alloc_valid_o, alloc_preg_o, count_o, err_o
    );
endinterface

// File: rtl/free_list.sv
// Circular free physical-register list with per-checkpoint head snapshots, so branch
// recovery and flush restore in-flight pregs by pointer moves alone.
module free_list #(
    parameter int unsigned NUM_PREGS = 128,
    parameter int unsigned NUM_AREGS = 32,
    parameter int unsigned CKPT_N    = 32
) (
    input logic       clk,
    input logic       rst,
    free_list_if.slave bus
);
    localparam int unsigned DEPTH  = NUM_PREGS - NUM_AREGS;
    localparam int unsigned PREG_W = $clog2(NUM_PREGS);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic             lap;
        logic [IDX_W-1:0] idx;
    } ptr_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        ptr_t r;
        if (p.idx == IDX_W'(DEPTH - 1)) begin
            r.idx = '0;
            r.lap = ~p.lap;
        end else begin
            r.idx = p.idx + IDX_W'(1);
            r.lap = p.lap;
        end
        return r;
    endfunction

    logic [PREG_W-1:0] ring_q [DEPTH];
    ptr_t              ckpt_q [CKPT_N];
    ptr_t              head_q, head_d;
    ptr_t              tail_q, tail_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  count;
    logic              empty, full;
    logic              alloc_fire, free_fire, ckpt_we;

    // Distance tail - head over the 2*DEPTH lap space.
    always_comb begin
        if (head_q.lap == tail_q.lap) begin
            count = CNT_W'(tail_q.idx) - CNT_W'(head_q.idx);
        end else begin
            count = CNT_W'(DEPTH) - CNT_W'(head_q.idx) + CNT_W'(tail_q.idx);
        end
    end

    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(DEPTH));
    assign alloc_fire = bus.alloc_req_i && !empty;
    assign free_fire  = bus.free_req_i && (bus.free_preg_i != '0) && !full;
    assign ckpt_we    = bus.checkpoint_take_i && !bus.recover_i && !bus.flush_i;

    assign bus.alloc_valid_o = !empty;
    assign bus.alloc_preg_o  = empty ? '0 : ring_q[head_q.idx];
    assign bus.count_o       = count;
    assign bus.err_o         = err_q;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        err_d  = err_q;
        if (free_fire) begin
            tail_d = ptr_inc(tail_q);
        end
        if (bus.free_req_i && (bus.free_preg_i != '0) && full) begin
            err_d = 1'b1;
        end
        if (bus.recover_i) begin
            head_d = ckpt_q[bus.recover_tag_i];
        end else if (bus.flush_i) begin
            // Head sits one full lap behind tail: every ring slot is free again.
            head_d = '{lap: ~tail_d.lap, idx: tail_d.idx};
        end else if (alloc_fire) begin
            head_d = ptr_inc(head_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '{lap: 1'b0, idx: '0};
            tail_q <= '{lap: 1'b1, idx: '0};
            err_q  <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ring_q[i] <= PREG_W'(NUM_AREGS + i);
            end
            for (int unsigned i = 0; i < CKPT_N; i++) begin
                ckpt_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            err_q  <= err_d;
            if (free_fire) begin
                ring_q[tail_q.idx] <= bus.free_preg_i;
            end
            if (ckpt_we) begin
                ckpt_q[bus.checkpoint_tag_i] <= head_d;
            end
        end
    end
endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Circular free-physical-register list that sits between ROB commit and rename.
- Supplies destination pregs to rename on allocate and reclaims the old pregs that the ROB frees on commit.
- Snapshots its read pointer per branch checkpoint so that recover and flush return in-flight pregs with no scanning.
- Pregs 0..NUM_AREGS-1 are never in the list at reset (identity arch mapping); p0 is never accepted.

Parameters:
- NUM_PREGS, `PREG_NUM (128): total physical registers; PREG_W = $clog2(NUM_PREGS).
- NUM_AREGS, 32: architectural registers.
- DEPTH, NUM_PREGS-NUM_AREGS (96): ring slots.
- CKPT_N, `ROB_DEPTH: checkpoint table entries, indexed by ROB tag (ROB_W bits).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush_i  in  1  full pipeline flush; all in-flight pregs return to the list
- recover_i  in  1  branch recovery
- recover_tag_i  in  ROB_W  checkpoint to restore
- checkpoint_take_i  in  1  record checkpoint this cycle
- checkpoint_tag_i  in  ROB_W  checkpoint slot
- alloc_req_i  in  1  rename requests one preg
- alloc_valid_o  out  1  list non-empty; alloc_preg_o is valid
- alloc_preg_o  out  PREG_W  preg at head (combinational)
- free_req_i  in  1  ROB commit frees a preg
- free_preg_i  in  PREG_W  preg being freed
- count_o  out  $clog2(DEPTH+1)  free pregs available
- err_o  out  1  sticky overflow error

Behaviour:
- State:
  - ring[DEPTH] of PREG_W.
  - head and tail, each an index 0..DEPTH-1 plus a lap bit; increment wraps DEPTH-1 -> 0 and toggles lap.
  - count = tail-head over the 2*DEPTH lap space: same lap gives tail_idx-head_idx; different lap gives DEPTH-head_idx+tail_idx.
  - ckpt_head[CKPT_N] and err.
- Reset (async, rst=1):
  - ring[i] = NUM_AREGS+i; head = {lap0, 0}; tail = {lap1, 0} (full); ckpt_head[*] = 0; err = 0.
  - Outputs: alloc_valid_o=1, alloc_preg_o=NUM_AREGS, count_o=DEPTH, err_o=0.
  - Reset mid-operation discards all state immediately.
- Combinational outputs:
  - alloc_valid_o = (count != 0).
  - alloc_preg_o = ring[head_idx]; it is 0 when empty.
  - count_o = count.
- Fire signals:
  - alloc_fire = alloc_req_i && alloc_valid_o. Rename consumes alloc_preg_o in the same cycle; head advances at the next edge.
  - free_fire = free_req_i && free_preg_i != 0 && count != DEPTH.
  - free_req_i with count == DEPTH does not write and sets err (sticky until reset).
  - free_req_i with free_preg_i == 0 is ignored, with no error.
  - On free_fire, ring[tail_idx] <= free_preg_i and tail advances.
  - A freed preg becomes visible the next cycle. There is no same-cycle bypass when empty.
- Priority per edge, highest first: recover_i > flush_i > normal.
- recover_i:
  - head <= ckpt_head[recover_tag_i].
  - alloc_req_i and checkpoint_take_i are ignored.
  - free_fire is still applied to tail, because the ROB retires during recover.
- flush_i:
  - head <= {~tail.lap, tail.idx}, using the tail after any free_fire; count becomes DEPTH.
  - Alloc and checkpoint are ignored. The ROB never frees during flush; a free that does arrive is still applied as normal.
- Normal cycle:
  - Apply alloc_fire and free_fire independently.
  - Simultaneous alloc_fire and free_fire leave count unchanged.
  - Alloc at count=0 does not fire even with a same-cycle free.
  - checkpoint_take_i writes ckpt_head[checkpoint_tag_i] <= head after this cycle's alloc_fire (head+1 if alloc_fire, else head).
- Correctness invariant: in-order commit keeps ring slots [tail, head) holding exactly the in-flight allocated pregs, so the pointer restore alone is sufficient. No data moves.

Test Plan:
- Reset, then sample -> alloc_preg_o=32, alloc_valid_o=1, count_o=96, err_o=0.
- Hold alloc_req_i for 97 cycles -> grants pregs 32..127 in order; after the 96th, count_o=0, alloc_valid_o=0, and the 97th request is not granted.
- From empty, free p5 with alloc_req_i=1 in the same cycle -> no grant that cycle; next cycle alloc_preg_o=5, count_o=1.
- From reset:
  - Alloc 32,33,34.
  - Alloc 35 with checkpoint_take_i and tag=4.
  - Alloc 36,37.
  - recover_i with tag=4 together with free p9.
  - Expect: next cycle alloc_preg_o=36 and count_o=93; subsequent allocs return 36,37,38,...
- From reset:
  - Alloc 10 (32..41), then free p7 and p8.
  - Flush.
  - Expect: count_o=96 and alloc_preg_o=34; subsequent allocs return 34..127 followed by 7 and 8.
- At reset (full):
  - Free p0 -> ignored, err_o=0.
  - Free p40 -> err_o=1 and stays 1, count_o stays 96.
  - Async rst pulse mid-stream -> immediate return to reset values.
